// File: rtl/fsmc_regfile_slave.sv
// fsmc_regfile_slave
// FSMC (STM32 external-memory bus) slave with a 2**AW x DW read/write
// register file. All bus pins are asynchronous to clk and pass through
// 2-flop synchronisers. Writes commit on the trailing (rising) edge of NWE.
// Reads drive d_out with d_oe for the top-level tristate pads. The register
// file is exported flat on regs for LEDs and other fabric logic.

module fsmc_regfile_slave #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    aNE,
    input  logic                    aNOE,
    input  logic                    aNWE,
    input  logic [AW-1:0]           aA,
    input  logic [DW-1:0]           aD,
    output logic [DW-1:0]           d_out,
    output logic                    d_oe,
    output logic [(2**AW)*DW-1:0]   regs,
    output logic                    wr_strobe,
    output logic [AW-1:0]           wr_addr,
    output logic                    rd_strobe,
    output logic                    proto_err
);

    localparam int NREGS = 2**AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    // Synchroniser stages: *_q1 is the metastability flop, r_s* the usable sample
    logic            r_ne_q1,  r_sNE;
    logic            r_noe_q1, r_sNOE;
    logic            r_nwe_q1, r_sNWE;
    logic [AW-1:0]   r_a_q1,   r_sA;
    logic [DW-1:0]   r_d_q1,   r_sD;

    // Transaction state
    state_t          r_state;
    logic            r_armed;
    logic [AW-1:0]   r_lat_a;
    logic [DW-1:0]   r_lat_d;
    logic [DW-1:0]   r_regs [NREGS];

    // Registered outputs
    logic [DW-1:0]   r_d_out;
    logic            r_d_oe;
    logic            r_wr_strobe;
    logic [AW-1:0]   r_wr_addr;
    logic            r_rd_strobe;
    logic            r_proto_err;

    // Control-pin synchronisers. Chip select resets to "asserted" so that the
    // slave stays disarmed until it has genuinely seen NE high after reset;
    // NOE/NWE reset to their idle (high) level so no strobe is implied.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ne_q1  <= 1'b0;
            r_sNE    <= 1'b0;
            r_noe_q1 <= 1'b1;
            r_sNOE   <= 1'b1;
            r_nwe_q1 <= 1'b1;
            r_sNWE   <= 1'b1;
        end else begin
            r_ne_q1  <= aNE;
            r_sNE    <= r_ne_q1;
            r_noe_q1 <= aNOE;
            r_sNOE   <= r_noe_q1;
            r_nwe_q1 <= aNWE;
            r_sNWE   <= r_nwe_q1;
        end
    end

    // Address/data synchronisers; only sampled by the FSM when a strobe is
    // active, so they carry no reset.
    always_ff @(posedge clk) begin
        r_a_q1 <= aA;
        r_sA   <= r_a_q1;
        r_d_q1 <= aD;
        r_sD   <= r_d_q1;
    end

    // Bus transaction FSM, register file and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_armed     <= 1'b0;
            r_lat_a     <= '0;
            r_lat_d     <= '0;
            r_d_out     <= '0;
            r_d_oe      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_rd_strobe <= 1'b0;
            r_proto_err <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_strobe <= 1'b0;
            r_rd_strobe <= 1'b0;

            // A bus cycle that was already running when reset lifted must be
            // ignored; only arm once chip select has been seen deasserted.
            if (r_sNE) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_sNE && !r_sNOE && !r_sNWE) begin
                        // Read and write strobes together: illegal, do nothing
                        r_proto_err <= 1'b1;
                    end else if (r_armed && !r_sNE && !r_sNWE && r_sNOE) begin
                        r_state <= S_WRITE;
                        r_lat_a <= r_sA;
                        r_lat_d <= r_sD;
                    end else if (r_armed && !r_sNE && !r_sNOE && r_sNWE) begin
                        r_state     <= S_READ;
                        r_d_out     <= r_regs[r_sA];
                        r_d_oe      <= 1'b1;
                        r_rd_strobe <= 1'b1;
                    end
                end

                S_WRITE: begin
                    if (r_sNWE) begin
                        // Trailing edge of NWE: commit the last sample taken
                        r_regs[r_lat_a] <= r_lat_d;
                        r_wr_addr       <= r_lat_a;
                        r_wr_strobe     <= 1'b1;
                        r_state         <= S_IDLE;
                    end else if (r_sNE) begin
                        // Chip select dropped before NWE rose: abort, no commit
                        r_proto_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        // Keep tracking the bus so the final value before the
                        // NWE rise is what lands in the register
                        r_lat_a <= r_sA;
                        r_lat_d <= r_sD;
                    end
                end

                S_READ: begin
                    if (!r_sNWE) begin
                        r_proto_err <= 1'b1;
                        r_d_oe      <= 1'b0;
                        r_d_out     <= '0;
                        r_state     <= S_IDLE;
                    end else if (r_sNOE || r_sNE) begin
                        r_d_oe  <= 1'b0;
                        r_d_out <= '0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Flatten the register file: register i occupies regs[i*DW +: DW]
    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : g_flat
            assign regs[g*DW +: DW] = r_regs[g];
        end
    endgenerate

    assign d_out     = r_d_out;
    assign d_oe      = r_d_oe;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign rd_strobe = r_rd_strobe;
    assign proto_err = r_proto_err;

endmodule

// File: doc/fsmc_regfile_slave.md
# fsmc_regfile_slave

Parametrised FSMC (STM32 external-memory bus) slave with a read/write register file, successor to the single-bit write-only bus slave. Runs in the PLL clock domain, synchronises all asynchronous bus pins internally, commits writes on the trailing edge of NWE and serves reads by driving a data word with an output-enable for the top-level tristate pads. Register contents are exported flat for LEDs and other fabric logic.

## Interface
- AW, 4: address bits; NREGS = 2**AW registers, fully decoded.
- DW, 16: data/register width.
- clk  in  1  PLL system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- aNE  in  1  async chip select, active low.
- aNOE  in  1  async output enable, active low.
- aNWE  in  1  async write enable, active low.
- aA  in  AW  async address.
- aD  in  DW  async data from pads (input side).
- d_out  out  DW  read data to pads.
- d_oe  out  1  pad output enable, high = drive d_out.
- regs  out  NREGS*DW  register file, reg i at bits [i*DW +: DW].
- wr_strobe  out  1  one-cycle pulse per committed write.
- wr_addr  out  AW  address of last committed write.
- rd_strobe  out  1  one-cycle pulse per read start.
- proto_err  out  1  sticky protocol-error flag.

## Operation
- Every a* input passes through its own 2-flop synchroniser (W = port width) → sNE, sNOE, sNWE, sA, sD.
- Reset: state IDLE, armed=0, all registers 0, d_out=0, d_oe=0, wr_strobe=0, wr_addr=0, rd_strobe=0, proto_err=0, latches 0.
- armed: set when sNE=1 sampled; cleared only by rst. No transaction starts while armed=0 (a cycle interrupted by reset is ignored, never half-committed).
- FSM states IDLE, WRITE, READ:
  - IDLE, armed, sNE=0, sNWE=0, sNOE=1 → WRITE; latch sA, sD.
  - IDLE, armed, sNE=0, sNOE=0, sNWE=1 → READ; d_out←regs[sA], d_oe←1, rd_strobe←1.
  - IDLE, sNE=0, sNOE=0, sNWE=0 → proto_err←1, stay IDLE.
  - WRITE, sNWE=0, sNE=0: re-latch sA, sD each cycle (last sample before NWE rise wins).
  - WRITE, sNWE=1 (any sNE): regs[latched addr]←latched data, wr_addr←addr, wr_strobe←1 → IDLE.
  - WRITE, sNE=1, sNWE=0: abort, no commit, proto_err←1 → IDLE.
  - READ, sNOE=0 and sNE=0: hold d_out, d_oe stable (no register can change).
  - READ, sNOE=1 or sNE=1: d_oe←0, d_out←0 → IDLE.
  - READ, sNWE=0: proto_err←1, d_oe←0, d_out←0 → IDLE.
- Strobes are high exactly one cycle per event.
- Back-to-back transactions: a new one may start the cycle after returning to IDLE; no extra gap needed.

## Timing
- Pin edge before clock edge k is visible as s* after edge k+1.
- Write: aNWE rises before edge k → regs updated and wr_strobe high after edge k+2 (3-cycle latency); data/address must be stable at pins ≥2 clk before NWE rise.
- Read: aNOE falls (NE low, NWE high) before edge k → d_oe=1 and d_out valid after edge k+2; FSMC read setup must cover ≥3 clk plus pad delay.
- Read end: aNOE rises before edge k → d_oe=0 after edge k+2.
- rst dominates everything in the cycle asserted; outputs at reset values the cycle after.

## Test plan
- AW=4, DW=16: write 0xBEEF to addr 5 → regs[5]=0xBEEF, wr_strobe one cycle 3 clk after NWE rise, wr_addr=5, other regs 0.
- Write 0x1234 to addr 15, then read addr 15 → rd_strobe once, d_oe high 3 clk after NOE fall, d_out=0x1234 held until NOE rise; d_oe low 3 clk after.
- Back-to-back writes 0x0001→addr 0, 0x0002→addr 1 with 1 clk NE-high gap → both committed, two wr_strobes.
- Data changes while NWE low (0xAAAA then 0x5555 before rise) → register gets 0x5555.
- NE rises while NWE still low → no commit, proto_err=1; NOE and NWE both low → proto_err=1, d_oe stays 0.
- rst asserted mid-write with NE held low → no commit after reset; first commit only after NE seen high and a full new cycle.
